// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : Oversample tick generator, data_ready/clr_ready handshake and
//               show-ahead receive FIFO with sticky overrun for a uart_rx core.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [15:0]       baud_div,
    output logic              rx_en,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              clr_ready,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam logic [ADDR_W:0] C_FULL_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         tcnt_q, tcnt_d;
    logic                rx_en_q, rx_en_d;
    logic                clr_ready_q, clr_ready_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          mem [DEPTH];

    logic                w_push_req;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push_ok;
    logic                w_drop;

    // Tick generator: >= compare so a shrinking divisor fires on the next edge.
    always_comb begin
        tcnt_d  = tcnt_q;
        rx_en_d = 1'b0;
        if (!enable) begin
            tcnt_d = 16'd0;
        end else if (tcnt_q >= baud_div) begin
            tcnt_d  = 16'd0;
            rx_en_d = 1'b1;
        end else begin
            tcnt_d = tcnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_ready_d = clr_ready_q;
        w_push_req  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_ready) begin
                    w_push_req  = 1'b1;
                    clr_ready_d = 1'b1;
                    state_d     = S_ACK;
                end
            end
            S_ACK: begin
                if (!rx_ready) begin
                    clr_ready_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                clr_ready_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // A push into a full FIFO is still accepted when a pop frees the head slot.
    always_comb begin
        w_empty   = (count_q == '0);
        w_full    = (count_q == C_FULL_CNT);
        w_pop     = rd_en && !w_empty;
        w_push_ok = w_push_req && (!w_full || w_pop);
        w_drop    = w_push_req && w_full && !w_pop;

        wr_ptr_d  = w_push_ok ? (wr_ptr_q + ADDR_W'(1)) : wr_ptr_q;
        rd_ptr_d  = w_pop     ? (rd_ptr_q + ADDR_W'(1)) : rd_ptr_q;

        count_d = count_q;
        case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase

        overrun_d = overrun_q;
        if (w_drop) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tcnt_q      <= 16'd0;
            rx_en_q     <= 1'b0;
            clr_ready_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            rx_en_q     <= rx_en_d;
            clr_ready_q <= clr_ready_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            mem[wr_ptr_q] <= rx_data;
        end
    end

    assign rx_en     = rx_en_q;
    assign clr_ready = clr_ready_q;
    assign rd_data   = mem[rd_ptr_q];
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = count_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Directed self-checking bench for uart_rx_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] baud_div = 16'd0;
    logic        rx_en;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready = 1'b0;
    logic        clr_ready;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        overrun;
    logic        ovr_clr = 1'b0;

    int checks   = 0;
    int failures = 0;

    uart_rx_ctrl #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .baud_div  (baud_div),
        .rx_en     (rx_en),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .clr_ready (clr_ready),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Receiver model: raise data_ready, wait for clr_ready, hold, then release.
    task automatic send(input logic [7:0] b, input int hold);
        int k;
        rx_data  = b;
        rx_ready = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (!clr_ready && k < 8);
        check("clr_ready_rise", {31'd0, clr_ready}, 32'd1);
        repeat (hold - 1) tick();
        rx_ready = 1'b0;
        tick();
    endtask

    initial begin
        logic [11:0] pat12;
        logic [3:0]  pat4;
        logic [7:0]  exp_b;

        // Reset state
        tick();
        tick();
        check("rst_rx_en",     {31'd0, rx_en},     32'd0);
        check("rst_clr_ready", {31'd0, clr_ready}, 32'd0);
        check("rst_overrun",   {31'd0, overrun},   32'd0);
        check("rst_count",     {27'd0, count},     32'd0);
        check("rst_empty",     {31'd0, empty},     32'd1);
        check("rst_full",      {31'd0, full},      32'd0);

        // Tick period baud_div+1 = 4
        rst      = 1'b0;
        enable   = 1'b1;
        baud_div = 16'd3;
        pat12    = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            pat12[i] = rx_en;
        end
        check("tick_div3", {20'd0, pat12}, 32'h888);
        enable = 1'b0;
        tick();
        check("tick_disable", {31'd0, rx_en}, 32'd0);

        // baud_div=0 -> tick every cycle
        enable   = 1'b1;
        baud_div = 16'd0;
        pat4     = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pat4[i] = rx_en;
        end
        check("tick_div0", {28'd0, pat4}, 32'hF);
        enable = 1'b0;
        tick();

        // Lowering baud_div below tcnt fires on the next edge
        enable   = 1'b1;
        baud_div = 16'd7;
        pat4     = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pat4[i] = rx_en;
        end
        tick();
        check("tick_pre_lower", {28'd0, pat4}, 32'd0);
        baud_div = 16'd2;
        tick();
        check("tick_lowered", {31'd0, rx_en}, 32'd1);
        enable = 1'b0;
        tick();

        // Single byte with data_ready held three cycles: one push only
        rx_data  = 8'hA5;
        rx_ready = 1'b1;
        tick();
        check("a5_count",   {27'd0, count},     32'd1);
        check("a5_data",    {24'd0, rd_data},   32'hA5);
        check("a5_clr",     {31'd0, clr_ready}, 32'd1);
        tick();
        tick();
        check("a5_hold_count", {27'd0, count},     32'd1);
        check("a5_hold_clr",   {31'd0, clr_ready}, 32'd1);
        rx_ready = 1'b0;
        tick();
        check("a5_clr_fall", {31'd0, clr_ready}, 32'd0);
        check("a5_count_end", {27'd0, count},    32'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("a5_popped_empty", {31'd0, empty}, 32'd1);

        // Fill to 16, then overflow
        for (int i = 0; i < 16; i++) send(8'(i), 1);
        check("fill_full",  {31'd0, full},  32'd1);
        check("fill_count", {27'd0, count}, 32'd16);
        send(8'h10, 1);
        check("ovf_overrun", {31'd0, overrun}, 32'd1);
        check("ovf_count",   {27'd0, count},   32'd16);
        check("ovf_head",    {24'd0, rd_data}, 32'h00);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_cleared", {31'd0, overrun}, 32'd0);

        // Push and pop on the same edge while full
        rx_data  = 8'h20;
        rx_ready = 1'b1;
        rd_en    = 1'b1;
        tick();
        rx_ready = 1'b0;
        rd_en    = 1'b0;
        check("fullpp_count",   {27'd0, count},   32'd16);
        check("fullpp_overrun", {31'd0, overrun}, 32'd0);
        check("fullpp_head",    {24'd0, rd_data}, 32'h01);
        tick();

        // Drain in order
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? 8'(i + 1) : 8'h20;
            check("drain_data", {24'd0, rd_data}, {24'd0, exp_b});
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        check("drain_empty", {31'd0, empty}, 32'd1);
        check("drain_count", {27'd0, count}, 32'd0);

        // Pop while empty is ignored; push+pop while empty is push only
        rd_en = 1'b1;
        tick();
        check("emptypop_count", {27'd0, count}, 32'd0);
        rx_data  = 8'h33;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        rd_en    = 1'b0;
        check("emptypp_count", {27'd0, count},   32'd1);
        check("emptypp_data",  {24'd0, rd_data}, 32'h33);
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("emptypp_drained", {31'd0, empty}, 32'd1);

        // Drop and ovr_clr on the same edge: set wins
        for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1);
        rx_data  = 8'h99;
        rx_ready = 1'b1;
        ovr_clr  = 1'b1;
        tick();
        rx_ready = 1'b0;
        ovr_clr  = 1'b0;
        check("setwins_overrun", {31'd0, overrun}, 32'd1);
        check("setwins_count",   {27'd0, count},   32'd16);
        tick();
        check("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Reset mid-handshake, byte recaptured after release
        enable   = 1'b1;
        baud_div = 16'd0;
        rx_data  = 8'h5A;
        rx_ready = 1'b1;
        tick();
        check("prerst_clr", {31'd0, clr_ready}, 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_clr",     {31'd0, clr_ready}, 32'd0);
        check("midrst_count",   {27'd0, count},     32'd0);
        check("midrst_rx_en",   {31'd0, rx_en},     32'd0);
        check("midrst_overrun", {31'd0, overrun},   32'd0);
        rst = 1'b0;
        tick();
        check("recap_count", {27'd0, count},     32'd1);
        check("recap_data",  {24'd0, rd_data},   32'h5A);
        check("recap_clr",   {31'd0, clr_ready}, 32'd1);
        tick();
        check("recap_once", {27'd0, count}, 32'd1);
        rx_ready = 1'b0;
        tick();
        check("recap_clr_fall", {31'd0, clr_ready}, 32'd0);
        check("recap_count_end", {27'd0, count},    32'd1);
        enable = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
